// File: rtl/reg_file_server_pkg.sv
// Shared types and default geometry for the integer register file and its
// pending-write scoreboard.
package reg_file_server_pkg;

  localparam int RF_NREGS  = 32;
  localparam int RF_XLEN   = 32;
  localparam int RF_PEND_W = 2;

  typedef logic [$clog2(RF_NREGS)-1:0] reg_addr_t;
  typedef logic [RF_XLEN-1:0]          xlen_t;

  localparam reg_addr_t ZERO_REG = '0;

endpackage

// File: rtl/regfile_read_if.sv
// One combinational register-file read port: the decode stage drives addr,
// the register file returns val in the same cycle.
interface regfile_read_if #(
  parameter int NREGS = 32,
  parameter int XLEN  = 32
);

  logic [$clog2(NREGS)-1:0] addr;
  logic [XLEN-1:0]          val;

  modport Client (output addr, input val);
  modport Server (input addr, output val);

endinterface

// File: rtl/reg_file_server_pend_scoreboard.sv
// Per-register pending-write counters: alloc/retire bookkeeping, allocReady
// back-pressure and busy lookup for the two read ports (REGFILE_BYPASS_EN
// lets a same-cycle final retire clear busy).
module pend_scoreboard
  import reg_file_server_pkg::*;
#(
  parameter int NREGS  = RF_NREGS,
  parameter int PEND_W = RF_PEND_W
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     alloc_valid,
  input  logic [$clog2(NREGS)-1:0] alloc_addr,
  output logic                     alloc_ready,
  input  logic                     wb_valid,
  input  logic [$clog2(NREGS)-1:0] wb_addr,
  input  logic [$clog2(NREGS)-1:0] rd0_addr,
  input  logic [$clog2(NREGS)-1:0] rd1_addr,
  output logic                     busy0,
  output logic                     busy1
);

  localparam int AW = $clog2(NREGS);
  localparam logic [PEND_W-1:0] PEND_MAX = '1;
  localparam logic [PEND_W-1:0] PEND_ONE = PEND_W'(1);

  logic [PEND_W-1:0] pend_q [NREGS];
  logic [PEND_W-1:0] pend_d [NREGS];
  logic              alloc_fire;
  logic              retire_fire;
  logic [NREGS-1:0]  alloc_hit;
  logic [NREGS-1:0]  retire_hit;

  // A retire to a full register frees a slot in the same cycle, so it may
  // accept an alloc to that register without exceeding PEND_MAX.
  always_comb begin
    retire_fire = wb_valid && (wb_addr != '0);
    alloc_ready = (alloc_addr == '0)
               || (pend_q[alloc_addr] != PEND_MAX)
               || (retire_fire && (wb_addr == alloc_addr));
    alloc_fire  = alloc_valid && alloc_ready && (alloc_addr != '0);
  end

  always_comb begin
    alloc_hit  = '0;
    retire_hit = '0;
    for (int r = 1; r < NREGS; r++) begin
      alloc_hit[r]  = alloc_fire  && (alloc_addr == AW'(r));
      retire_hit[r] = retire_fire && (wb_addr == AW'(r));
    end
  end

  // Retire with nothing pending is a protocol error; saturate rather than wrap.
  always_comb begin
    for (int r = 0; r < NREGS; r++) begin
      pend_d[r] = pend_q[r];
      if (alloc_hit[r] && !retire_hit[r]) begin
        pend_d[r] = pend_q[r] + PEND_ONE;
      end else if (retire_hit[r] && !alloc_hit[r] && (pend_q[r] != '0)) begin
        pend_d[r] = pend_q[r] - PEND_ONE;
      end
    end
    pend_d[0] = '0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int r = 0; r < NREGS; r++) begin
        pend_q[r] <= '0;
      end
    end else begin
      pend_q <= pend_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && retire_fire) begin
      assert (pend_q[wb_addr] != '0);
    end
  end

  always_comb begin
    busy0 = (rd0_addr != '0) && (pend_q[rd0_addr] != '0);
    busy1 = (rd1_addr != '0) && (pend_q[rd1_addr] != '0);
`ifdef REGFILE_BYPASS_EN
    if (retire_fire && (wb_addr == rd0_addr) && (pend_q[rd0_addr] == PEND_ONE)) begin
      busy0 = 1'b0;
    end
    if (retire_fire && (wb_addr == rd1_addr) && (pend_q[rd1_addr] == PEND_ONE)) begin
      busy1 = 1'b0;
    end
`endif
  end

endmodule

// File: rtl/reg_file_server.sv
// Architectural integer register file: two combinational read ports, one
// writeback port, pending-write scoreboard. Optional macro REGFILE_BYPASS_EN.
module reg_file_server
  import reg_file_server_pkg::*;
#(
  parameter int NREGS  = RF_NREGS,
  parameter int XLEN   = RF_XLEN,
  parameter int PEND_W = RF_PEND_W
) (
  input  logic                     clk,
  input  logic                     rst,
  regfile_read_if.Server           read0,
  regfile_read_if.Server           read1,
  input  logic                     wbValid,
  input  logic [$clog2(NREGS)-1:0] wbAddr,
  input  logic [XLEN-1:0]          wbData,
  input  logic                     allocValid,
  input  logic [$clog2(NREGS)-1:0] allocAddr,
  output logic                     allocReady,
  output logic                     busy0,
  output logic                     busy1
);

  logic [XLEN-1:0] regs_q [NREGS];
  logic [XLEN-1:0] regs_d [NREGS];
  logic [XLEN-1:0] rd0_val;
  logic [XLEN-1:0] rd1_val;
  logic            wb_fire;

  pend_scoreboard #(
    .NREGS  (NREGS),
    .PEND_W (PEND_W)
  ) u_pend_scoreboard (
    .clk         (clk),
    .rst         (rst),
    .alloc_valid (allocValid),
    .alloc_addr  (allocAddr),
    .alloc_ready (allocReady),
    .wb_valid    (wbValid),
    .wb_addr     (wbAddr),
    .rd0_addr    (read0.addr),
    .rd1_addr    (read1.addr),
    .busy0       (busy0),
    .busy1       (busy1)
  );

  assign wb_fire = wbValid && (wbAddr != '0);

  always_comb begin
    regs_d = regs_q;
    if (wb_fire) begin
      regs_d[wbAddr] = wbData;
    end
    regs_d[0] = '0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int r = 0; r < NREGS; r++) begin
        regs_q[r] <= '0;
      end
    end else begin
      regs_q <= regs_d;
    end
  end

  // x0 reads as zero regardless of storage; bypass forwards the in-flight writeback.
  always_comb begin
    rd0_val = (read0.addr == '0) ? '0 : regs_q[read0.addr];
    rd1_val = (read1.addr == '0) ? '0 : regs_q[read1.addr];
`ifdef REGFILE_BYPASS_EN
    if (wb_fire && (wbAddr == read0.addr)) begin
      rd0_val = wbData;
    end
    if (wb_fire && (wbAddr == read1.addr)) begin
      rd1_val = wbData;
    end
`endif
  end

  assign read0.val = rd0_val;
  assign read1.val = rd1_val;

endmodule

// File: tb/tb_reg_file_server.sv
// Scoreboard bench for reg_file_server: stimulus queues expected outputs
// tagged with a cycle number, a negedge monitor pops and compares them.
module tb_reg_file_server;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        wbValid;
  logic [4:0]  wbAddr;
  logic [31:0] wbData;
  logic        allocValid;
  logic [4:0]  allocAddr;
  logic        allocReady;
  logic        busy0;
  logic        busy1;

  always #5 clk = ~clk;

  regfile_read_if #(.NREGS(32), .XLEN(32)) rd0_if ();
  regfile_read_if #(.NREGS(32), .XLEN(32)) rd1_if ();

  reg_file_server #(
    .NREGS  (32),
    .XLEN   (32),
    .PEND_W (2)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .read0      (rd0_if),
    .read1      (rd1_if),
    .wbValid    (wbValid),
    .wbAddr     (wbAddr),
    .wbData     (wbData),
    .allocValid (allocValid),
    .allocAddr  (allocAddr),
    .allocReady (allocReady),
    .busy0      (busy0),
    .busy1      (busy1)
  );

  typedef enum int {S_VAL0, S_VAL1, S_BUSY0, S_BUSY1, S_READY} sel_t;

  typedef struct {
    int          tag;
    sel_t        sel;
    string       name;
    logic [31:0] exp;
  } item_t;

  item_t q[$];
  int    cyc    = 0;
  int    errs   = 0;
  int    checks = 0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] actual(sel_t s);
    case (s)
      S_VAL0:  return rd0_if.val;
      S_VAL1:  return rd1_if.val;
      S_BUSY0: return {31'd0, busy0};
      S_BUSY1: return {31'd0, busy1};
      default: return {31'd0, allocReady};
    endcase
  endfunction

  always @(negedge clk) begin
    item_t it;
    while (q.size() > 0 && q[0].tag <= cyc) begin
      it = q.pop_front();
      checks++;
      if (it.tag != cyc) begin
        errs++;
        $display("FAIL %s: check missed (queued for cycle %0d, now %0d)", it.name, it.tag, cyc);
      end else if (actual(it.sel) !== it.exp) begin
        errs++;
        $display("FAIL %s: got %h expected %h", it.name, actual(it.sel), it.exp);
      end
    end
  end

  task automatic want(input sel_t s, input string n, input logic [31:0] v);
    item_t it;
    it.tag  = cyc;
    it.sel  = s;
    it.name = n;
    it.exp  = v;
    q.push_back(it);
  endtask

  // Advance one cycle, then apply this cycle's inputs.
  task automatic drive(input logic [4:0] a0, input logic [4:0] a1,
                       input logic wv, input logic [4:0] wa, input logic [31:0] wd,
                       input logic av, input logic [4:0] aa);
    @(posedge clk);
    #1;
    rd0_if.addr = a0;
    rd1_if.addr = a1;
    wbValid     = wv;
    wbAddr      = wa;
    wbData      = wd;
    allocValid  = av;
    allocAddr   = aa;
  endtask

  initial begin
    rd0_if.addr = '0;
    rd1_if.addr = '0;
    wbValid     = 1'b0;
    wbAddr      = '0;
    wbData      = '0;
    allocValid  = 1'b0;
    allocAddr   = '0;

    repeat (2) drive(0, 0, 0, 0, 0, 0, 0);

    // Reset state; write to x0 in the same cycle
    drive(5, 0, 1, 0, 32'hDEAD, 0, 5);
    rst = 1'b0;
    want(S_VAL0,  "rst_val_x5",  32'h0);
    want(S_VAL1,  "rst_val_x0",  32'h0);
    want(S_BUSY0, "rst_busy0",   32'h0);
    want(S_BUSY1, "rst_busy1",   32'h0);
    want(S_READY, "rst_ready",   32'h1);
    drive(0, 5, 0, 0, 0, 1, 0);
    want(S_VAL0,  "x0_after_wr", 32'h0);
    want(S_READY, "x0_alloc_rdy", 32'h1);
    drive(0, 0, 0, 0, 0, 0, 0);
    want(S_BUSY0, "x0_untracked", 32'h0);

    // Alloc x3, then retire it
    drive(3, 0, 0, 0, 0, 1, 3);
    want(S_READY, "x3_alloc_rdy", 32'h1);
    want(S_BUSY0, "x3_busy_pre",  32'h0);
    drive(3, 0, 0, 0, 0, 0, 0);
    want(S_BUSY0, "x3_busy",      32'h1);
    want(S_VAL0,  "x3_val_old",   32'h0);
    drive(3, 0, 1, 3, 32'h1234, 0, 0);
`ifdef REGFILE_BYPASS_EN
    want(S_VAL0,  "x3_wb_val",    32'h1234);
    want(S_BUSY0, "x3_wb_busy",   32'h0);
`else
    want(S_VAL0,  "x3_wb_val",    32'h0);
    want(S_BUSY0, "x3_wb_busy",   32'h1);
`endif
    drive(3, 0, 0, 0, 0, 0, 0);
    want(S_VAL0,  "x3_val_new",   32'h1234);
    want(S_BUSY0, "x3_busy_clr",  32'h0);

    // Fill x7 to the pending limit
    drive(0, 7, 0, 0, 0, 1, 7);
    want(S_READY, "x7_alloc1",    32'h1);
    drive(0, 7, 0, 0, 0, 1, 7);
    want(S_READY, "x7_alloc2",    32'h1);
    want(S_BUSY1, "x7_busy_p1",   32'h1);
    drive(0, 7, 0, 0, 0, 1, 7);
    want(S_READY, "x7_alloc3",    32'h1);
    drive(0, 7, 0, 0, 0, 1, 7);
    want(S_READY, "x7_full",      32'h0);
    want(S_BUSY1, "x7_busy_full", 32'h1);
    drive(0, 7, 1, 7, 32'h77, 1, 7);
    want(S_READY, "x7_full_retire", 32'h1);
    want(S_BUSY1, "x7_busy_swap", 32'h1);
    drive(0, 7, 0, 0, 0, 1, 7);
    want(S_READY, "x7_still_full", 32'h0);
    drive(0, 7, 1, 7, 32'h70, 0, 0);
    drive(0, 7, 1, 7, 32'h71, 0, 0);
    want(S_BUSY1, "x7_drain_p1",  32'h1);
    drive(0, 7, 1, 7, 32'h72, 0, 0);
    drive(0, 7, 0, 0, 0, 0, 0);
    want(S_BUSY1, "x7_drained",   32'h0);
    want(S_VAL1,  "x7_last_val",  32'h72);

    // Same-cycle alloc and retire on x9 with one pending
    drive(9, 0, 0, 0, 0, 1, 9);
    want(S_READY, "x9_alloc",     32'h1);
    drive(9, 0, 1, 9, 32'hA5A5, 1, 9);
    want(S_READY, "x9_both_rdy",  32'h1);
`ifdef REGFILE_BYPASS_EN
    want(S_VAL0,  "x9_both_val",  32'hA5A5);
`else
    want(S_VAL0,  "x9_both_val",  32'h0);
    want(S_BUSY0, "x9_both_busy", 32'h1);
`endif
    drive(9, 0, 0, 0, 0, 0, 0);
    want(S_BUSY0, "x9_still_busy", 32'h1);
    want(S_VAL0,  "x9_data",      32'hA5A5);

    // Alloc x4 while retiring x6
    drive(0, 0, 0, 0, 0, 1, 6);
    want(S_READY, "x6_alloc",     32'h1);
    drive(4, 6, 1, 6, 32'h55, 1, 4);
    want(S_READY, "x4_alloc",     32'h1);
    want(S_BUSY0, "x4_busy_pre",  32'h0);
`ifdef REGFILE_BYPASS_EN
    want(S_VAL1,  "x6_wb_val",    32'h55);
    want(S_BUSY1, "x6_wb_busy",   32'h0);
`else
    want(S_VAL1,  "x6_wb_val",    32'h0);
    want(S_BUSY1, "x6_wb_busy",   32'h1);
`endif
    drive(4, 6, 0, 0, 0, 0, 0);
    want(S_BUSY0, "x4_busy",      32'h1);
    want(S_BUSY1, "x6_not_busy",  32'h0);
    want(S_VAL1,  "x6_val",       32'h55);

    // Reset with allocations outstanding
    drive(0, 0, 0, 0, 0, 1, 2);
    drive(0, 0, 0, 0, 0, 1, 8);
    drive(2, 8, 0, 0, 0, 0, 0);
    want(S_BUSY0, "x2_busy",      32'h1);
    want(S_BUSY1, "x8_busy",      32'h1);
    drive(2, 8, 0, 0, 0, 1, 2);
    rst = 1'b1;
    drive(2, 8, 0, 0, 0, 0, 2);
    rst = 1'b0;
    want(S_BUSY0, "post_rst_busy0", 32'h0);
    want(S_BUSY1, "post_rst_busy1", 32'h0);
    want(S_READY, "post_rst_ready", 32'h1);
    drive(3, 9, 0, 0, 0, 0, 7);
    want(S_VAL0,  "post_rst_x3",  32'h0);
    want(S_VAL1,  "post_rst_x9",  32'h0);
    want(S_BUSY1, "post_rst_x9_busy", 32'h0);
    want(S_READY, "post_rst_x7_rdy", 32'h1);

    drive(0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 10 && q.size() > 0; i++) @(posedge clk);
    if (q.size() > 0) begin
      errs++;
      $display("FAIL drain: %0d checks never compared, expected 0", q.size());
    end
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
